scoreboard_mp: RTL and testbench

//  Multi-port register scoreboard for the in-order NPC pipeline, between ID issue and the WB stage(s).

---
 rtl/scoreboard_mp.sv | 139 +++++++++++++
 tb/tb_scoreboard_mp.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_mp.sv
// Multi-port register scoreboard: per-register in-flight write counters gating ID issue
// on RAW / WAW / saturation hazards, with NWB writeback ports, same-cycle WB bypass and flush.

module sb_reg_cnt #(
  parameter int CNT_W = 3,
  parameter int DW    = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             inc,
  input  logic [DW-1:0]    dec,
  output logic [CNT_W-1:0] cnt,
  output logic             uflow
);
  localparam int SW = CNT_W + DW + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    sum;

  // Signed-width arithmetic so an over-decrement shows up in the top bit.
  always_comb begin
    sum   = {{(DW+1){1'b0}}, cnt_q} + {{(SW-1){1'b0}}, inc} - {{(CNT_W+1){1'b0}}, dec};
    uflow = 1'b0;
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (sum[SW-1]) begin
      cnt_d = '0;
      uflow = 1'b1;
    end else begin
      cnt_d = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

module scoreboard_mp #(
  parameter  int NREG      = 32,
  parameter  int CNT_W     = 3,
  parameter  int NWB       = 2,
  parameter  int NSRC      = 2,
  parameter  int ZERO_REG  = 1,
  parameter  int WAW_STALL = 0,
  parameter  int BYPASS_WB = 1,
  localparam int AW        = $clog2(NREG)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              ex_ready,
  input  logic [NSRC*AW-1:0] rs_idx,
  input  logic [NSRC-1:0]   rs_en,
  input  logic [AW-1:0]     rd,
  input  logic              rf_wen,
  input  logic [NWB*AW-1:0] wb_rd,
  input  logic [NWB-1:0]    wb_rf_wen,
  input  logic              flush,
  output logic              id_stall,
  output logic              issue_fire,
  output logic              ex_flush,
  output logic [NREG-1:0]   pending,
  output logic              err
);
  localparam int DW = $clog2(NWB + 1);

  logic [NREG-1:0] inc, uflow, raw_hit, waw_hit, sat_hit;
  logic            hazard;
  logic            err_q, err_d;

  // One counter slice per register; index compares against the slice's own
  // constant, so out-of-range indices simply never match any slice.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    localparam logic [AW-1:0] IDX = AW'(gi);
    localparam bit            TRK = !(ZERO_REG != 0 && gi == 0);

    logic [CNT_W-1:0] cnt_l;
    logic [DW-1:0]    dec_l;
    logic             src_hit, live, rd_hit;

    always_comb begin
      dec_l = '0;
      for (int j = 0; j < NWB; j++)
        if (TRK && wb_rf_wen[j] && wb_rd[j*AW +: AW] == IDX) dec_l = dec_l + DW'(1);
    end

    always_comb begin
      src_hit = 1'b0;
      for (int k = 0; k < NSRC; k++)
        if (rs_en[k] && rs_idx[k*AW +: AW] == IDX) src_hit = 1'b1;
    end

    // With bypass, a source is clear when this cycle's writebacks retire every pending write.
    if (BYPASS_WB != 0) begin : g_byp
      assign live = ({{DW{1'b0}}, cnt_l} != {{CNT_W{1'b0}}, dec_l});
    end else begin : g_nobyp
      assign live = (cnt_l != '0);
    end

    assign rd_hit     = TRK && rf_wen && rd == IDX;
    assign raw_hit[gi] = TRK && src_hit && live;
    assign waw_hit[gi] = (WAW_STALL != 0) && rd_hit && cnt_l != '0;
    assign sat_hit[gi] = rd_hit && cnt_l == {CNT_W{1'b1}};
    assign inc[gi]     = issue_fire && rd_hit;
    assign pending[gi] = cnt_l != '0;

    sb_reg_cnt #(.CNT_W(CNT_W), .DW(DW)) u_cnt (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .inc   (inc[gi]),
      .dec   (dec_l),
      .cnt   (cnt_l),
      .uflow (uflow[gi])
    );
  end

  assign hazard     = |raw_hit || |waw_hit || |sat_hit;
  assign id_stall   = id_valid && hazard;
  assign issue_fire = id_valid && ex_ready && !hazard;
  assign ex_flush   = id_valid && ex_ready && hazard;

  always_comb begin
    err_d = err_q || |uflow;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
endmodule

// File: tb/tb_scoreboard_mp.sv
// Bench for scoreboard_mp: two configurations share one stimulus stream and are
// compared every cycle against a per-register counter model built from the rules.
module tb_scoreboard_mp;
  localparam int NREG = 32, AW = 5, NWB = 2, NSRC = 2;

  logic clock = 1'b0;
  logic reset;
  logic id_valid, ex_ready, rf_wen, flush;
  logic [NSRC*AW-1:0] rs_idx;
  logic [NSRC-1:0]    rs_en;
  logic [AW-1:0]      rd;
  logic [NWB*AW-1:0]  wb_rd;
  logic [NWB-1:0]     wb_rf_wen;

  logic stall_a, fire_a, exf_a, err_a, stall_b, fire_b, exf_b, err_b;
  logic [NREG-1:0] pend_a, pend_b;

  always #5 clock = ~clock;

  // Config a: defaults. Config b: CNT_W=2, x0 tracked, WAW stall on, no bypass.
  scoreboard_mp u_a (
    .clock(clock), .reset(reset), .id_valid(id_valid), .ex_ready(ex_ready),
    .rs_idx(rs_idx), .rs_en(rs_en), .rd(rd), .rf_wen(rf_wen), .wb_rd(wb_rd),
    .wb_rf_wen(wb_rf_wen), .flush(flush), .id_stall(stall_a), .issue_fire(fire_a),
    .ex_flush(exf_a), .pending(pend_a), .err(err_a)
  );

  scoreboard_mp #(.CNT_W(2), .ZERO_REG(0), .WAW_STALL(1), .BYPASS_WB(0)) u_b (
    .clock(clock), .reset(reset), .id_valid(id_valid), .ex_ready(ex_ready),
    .rs_idx(rs_idx), .rs_en(rs_en), .rd(rd), .rf_wen(rf_wen), .wb_rd(wb_rd),
    .wb_rf_wen(wb_rf_wen), .flush(flush), .id_stall(stall_b), .issue_fire(fire_b),
    .ex_flush(exf_b), .pending(pend_b), .err(err_b)
  );

  int cfg_cw[2]  = '{3, 2};
  int cfg_zr[2]  = '{1, 0};
  int cfg_waw[2] = '{0, 1};
  int cfg_byp[2] = '{1, 0};

  int m_cnt[2][NREG];
  int m_nxt[2][NREG];
  bit m_err[2];
  bit e_nxt[2];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit trk(int c, int r);
    return !(cfg_zr[c] != 0 && r == 0);
  endfunction

  function automatic int ndec(int c, int r);
    int n = 0;
    for (int j = 0; j < NWB; j++)
      if (wb_rf_wen[j] && int'(wb_rd[j*AW +: AW]) == r && trk(c, r)) n++;
    return n;
  endfunction

  function automatic bit haz(int c);
    bit h = 0;
    int r, e;
    for (int k = 0; k < NSRC; k++) begin
      r = int'(rs_idx[k*AW +: AW]);
      if (rs_en[k] && trk(c, r)) begin
        e = m_cnt[c][r] - (cfg_byp[c] != 0 ? ndec(c, r) : 0);
        if (e != 0) h = 1;
      end
    end
    r = int'(rd);
    if (rf_wen && trk(c, r)) begin
      if (cfg_waw[c] != 0 && m_cnt[c][r] != 0) h = 1;
      if (m_cnt[c][r] == (1 << cfg_cw[c]) - 1) h = 1;
    end
    return h;
  endfunction

  function automatic logic [31:0] m_pend(int c);
    logic [31:0] p = '0;
    for (int r = 0; r < NREG; r++) p[r] = (m_cnt[c][r] != 0);
    return p;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      m_err[c] = 0;
      for (int r = 0; r < NREG; r++) m_cnt[c][r] = 0;
    end
  endtask

  // Compare this cycle's outputs and work out the counter state after the next edge.
  task automatic eval_cycle();
    bit h, f;
    int v;
    for (int c = 0; c < 2; c++) begin
      h = haz(c);
      f = id_valid && ex_ready && !h;
      chk($sformatf("stall_c%0d", c), {31'd0, c == 0 ? stall_a : stall_b}, {31'd0, id_valid && h});
      chk($sformatf("fire_c%0d", c),  {31'd0, c == 0 ? fire_a : fire_b},   {31'd0, f});
      chk($sformatf("exfl_c%0d", c),  {31'd0, c == 0 ? exf_a : exf_b},     {31'd0, id_valid && ex_ready && h});
      chk($sformatf("pend_c%0d", c),  c == 0 ? pend_a : pend_b,            m_pend(c));
      chk($sformatf("err_c%0d", c),   {31'd0, c == 0 ? err_a : err_b},     {31'd0, m_err[c]});
      e_nxt[c] = m_err[c];
      for (int r = 0; r < NREG; r++) begin
        if (flush || !reset) begin
          m_nxt[c][r] = 0;
        end else begin
          v = m_cnt[c][r] + ((f && rf_wen && int'(rd) == r && trk(c, r)) ? 1 : 0) - ndec(c, r);
          if (v < 0) begin
            v = 0;
            e_nxt[c] = 1;
          end
          m_nxt[c][r] = v;
        end
      end
      if (!reset) e_nxt[c] = 0;
    end
  endtask

  task automatic step();
    @(negedge clock);
    eval_cycle();
    @(posedge clock);
    #1;
    for (int c = 0; c < 2; c++) begin
      m_err[c] = e_nxt[c];
      for (int r = 0; r < NREG; r++) m_cnt[c][r] = m_nxt[c][r];
    end
  endtask

  task automatic idle();
    id_valid = 0; ex_ready = 1; rs_idx = '0; rs_en = '0; rd = '0; rf_wen = 0;
    wb_rd = '0; wb_rf_wen = '0; flush = 0;
  endtask

  task automatic issue_rd(input int r);
    idle();
    id_valid = 1; rf_wen = 1; rd = AW'(r);
  endtask

  task automatic read_rs0(input int r);
    idle();
    id_valid = 1; rs_idx[0 +: AW] = AW'(r); rs_en = 2'b01;
  endtask

  initial begin
    reset = 0;
    idle();
    model_clear();
    id_valid = 1;
    step();
    step();
    reset = 1;
    idle();
    step();

    // RAW on rd=3, then WB bypass resolves it in-cycle only for config a.
    issue_rd(3);   step();
    read_rs0(3);   step();
    read_rs0(3);   wb_rd[0 +: AW] = AW'(3); wb_rf_wen = 2'b01; step();
    read_rs0(3);   step();

    // Dual WB on rd=7: 2 -> 0 clean; 1 -> 0 with underflow.
    issue_rd(7);   step();
    issue_rd(7);   step();
    idle(); wb_rd = {AW'(7), AW'(7)}; wb_rf_wen = 2'b11; step();
    issue_rd(7);   step();
    idle(); wb_rd = {AW'(7), AW'(7)}; wb_rf_wen = 2'b11; step();
    idle();        step();

    // Asynchronous reset mid-run with rd=5 pending twice.
    issue_rd(5);   step();
    issue_rd(5);   step();
    idle();        step();
    #2 reset = 0;
    #1;
    chk("async_pend_a", pend_a, 32'd0);
    chk("async_pend_b", pend_b, 32'd0);
    chk("async_err_a", {31'd0, err_a}, 32'd0);
    chk("async_err_b", {31'd0, err_b}, 32'd0);
    model_clear();
    id_valid = 1; step();
    reset = 1;
    read_rs0(5);   step();

    // Saturation on rd=4 (config b max 3), then issue+WB at the same time.
    for (int i = 0; i < 4; i++) begin issue_rd(4); step(); end
    idle(); wb_rd[0 +: AW] = AW'(4); wb_rf_wen = 2'b01; step();
    issue_rd(4); wb_rd[0 +: AW] = AW'(4); wb_rf_wen = 2'b01; step();
    idle();        step();

    // x0: untracked in a, tracked in b.
    issue_rd(0);   step();
    read_rs0(0); rf_wen = 1; rd = '0; step();
    idle();        step();

    // WAW on rd=9 in b, then flush clears everything.
    issue_rd(9);   step();
    issue_rd(9);   step();
    issue_rd(9); flush = 1; step();
    issue_rd(9);   step();
    idle(); wb_rd = {AW'(9), AW'(4)}; wb_rf_wen = 2'b11; step();

    // Randomized traffic over a small register window to keep hazards frequent.
    for (int i = 0; i < 400; i++) begin
      id_valid  = ($urandom_range(0, 9) < 8);
      ex_ready  = ($urandom_range(0, 9) < 8);
      rf_wen    = ($urandom_range(0, 9) < 7);
      rd        = AW'($urandom_range(0, 11));
      rs_idx    = {AW'($urandom_range(0, 11)), AW'($urandom_range(0, 11))};
      rs_en     = 2'($urandom_range(0, 3));
      wb_rd     = {AW'($urandom_range(0, 11)), AW'($urandom_range(0, 11))};
      wb_rf_wen = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      flush     = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
